// File: rtl/cgia_bus_arbiter_if.sv
// Bus bundle between the VID fetcher / CPU bridge, the arbiter and the video-RAM slave.
// master: requesters and slave model side; slave: the arbiter's view.
interface cgia_bus_arbiter_if;
    logic        vid_cyc_i;
    logic        vid_stb_i;
    logic [23:1] vid_adr_i;
    logic        vid_ack_o;
    logic        vid_err_o;
    logic        cpu_cyc_i;
    logic        cpu_stb_i;
    logic        cpu_we_i;
    logic [1:0]  cpu_sel_i;
    logic [23:1] cpu_adr_i;
    logic [15:0] cpu_dat_i;
    logic        cpu_ack_o;
    logic        cpu_err_o;
    logic [15:0] dat_o;
    logic [23:1] adr_o;
    logic [15:0] mdat_o;
    logic        we_o;
    logic [1:0]  sel_o;
    logic        cyc_o;
    logic        stb_o;
    logic        ack_i;
    logic [15:0] dat_i;
    logic [1:0]  gnt_o;

    modport master (
        output vid_cyc_i, vid_stb_i, vid_adr_i,
        output cpu_cyc_i, cpu_stb_i, cpu_we_i, cpu_sel_i, cpu_adr_i, cpu_dat_i,
        output ack_i, dat_i,
        input  vid_ack_o, vid_err_o, cpu_ack_o, cpu_err_o,
        input  dat_o, adr_o, mdat_o, we_o, sel_o, cyc_o, stb_o, gnt_o
    );

    modport slave (
        input  vid_cyc_i, vid_stb_i, vid_adr_i,
        input  cpu_cyc_i, cpu_stb_i, cpu_we_i, cpu_sel_i, cpu_adr_i, cpu_dat_i,
        input  ack_i, dat_i,
        output vid_ack_o, vid_err_o, cpu_ack_o, cpu_err_o,
        output dat_o, adr_o, mdat_o, we_o, sel_o, cyc_o, stb_o, gnt_o
    );
endinterface

// File: rtl/cgia_bus_arbiter.sv
// Video-RAM port arbiter: VID priority, CPU starvation bound, registered grant, gnt-gated mux.
// Optional slave-hang abort enabled by defining ARB_TIMEOUT_EN.
module cgia_bus_arbiter #(
    parameter int CPU_STARVE_MAX = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    cgia_bus_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'b00, VID = 2'b01, CPU = 2'b10} state_t;

    localparam int SW = $clog2(CPU_STARVE_MAX + 1);

    state_t        state;
    logic [SW-1:0] starve_cnt;
    logic          starved;
    logic          vid_own, cpu_own;
    logic          cyc, stb;
    logic          tmo_hit, blk_vid, blk_cpu;
    logic          vid_req, cpu_req;

    assign starved = (starve_cnt >= SW'(CPU_STARVE_MAX));
    assign vid_own = (state == VID);
    assign cpu_own = (state == CPU);

    // Everything toward the slave is gated by the grant, so reset silences the bus at once.
    assign cyc = (vid_own & bus.vid_cyc_i) | (cpu_own & bus.cpu_cyc_i);
    assign stb = (vid_own & bus.vid_cyc_i & bus.vid_stb_i) |
                 (cpu_own & bus.cpu_cyc_i & bus.cpu_stb_i);

    assign bus.gnt_o  = state;
    assign bus.cyc_o  = cyc;
    assign bus.stb_o  = stb;
    assign bus.adr_o  = ({23{vid_own}} & bus.vid_adr_i) | ({23{cpu_own}} & bus.cpu_adr_i);
    assign bus.mdat_o = {16{cpu_own}} & bus.cpu_dat_i;
    assign bus.we_o   = cpu_own & bus.cpu_we_i;
    assign bus.sel_o  = vid_own ? 2'b11 : (cpu_own ? bus.cpu_sel_i : 2'b00);
    assign bus.dat_o  = bus.dat_i;

    // An ack arriving after the owner dropped cyc/stb is discarded.
    assign bus.vid_ack_o = bus.ack_i & stb & vid_own;
    assign bus.cpu_ack_o = bus.ack_i & stb & cpu_own;

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;

    assign tmo_hit       = stb & ~bus.ack_i & (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign bus.vid_err_o = tmo_hit & vid_own;
    assign bus.cpu_err_o = tmo_hit & cpu_own;

    // An aborted owner stays locked out until it drops cyc.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            tmo_cnt <= '0;
            blk_vid <= 1'b0;
            blk_cpu <= 1'b0;
        end else begin
            tmo_cnt <= (stb & ~bus.ack_i & ~tmo_hit) ? tmo_cnt + 1'b1 : '0;
            blk_vid <= (tmo_hit & vid_own) | (blk_vid & bus.vid_cyc_i);
            blk_cpu <= (tmo_hit & cpu_own) | (blk_cpu & bus.cpu_cyc_i);
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo    = |TIMEOUT_CYCLES;
    assign tmo_hit       = 1'b0;
    assign blk_vid       = 1'b0;
    assign blk_cpu       = 1'b0;
    assign bus.vid_err_o = 1'b0;
    assign bus.cpu_err_o = 1'b0;
`endif

    assign vid_req = bus.vid_cyc_i & ~blk_vid;
    assign cpu_req = bus.cpu_cyc_i & ~blk_cpu;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            if (!bus.cpu_cyc_i || state == CPU) starve_cnt <= '0;
            else if (!starved)                  starve_cnt <= starve_cnt + 1'b1;

            if (tmo_hit) state <= IDLE;
            else begin
                case (state)
                    IDLE: begin
                        if (vid_req && !(cpu_req && starved)) state <= VID;
                        else if (cpu_req)                     state <= CPU;
                    end
                    // Preemption lands on an ack so VID never loses a transfer in flight.
                    VID: if (!bus.vid_cyc_i || (starved && bus.ack_i)) state <= IDLE;
                    CPU: if (!bus.cpu_cyc_i) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cgia_bus_arbiter.sv
// Directed scenarios plus a randomized run checked against a cycle-level reference model.
module tb_cgia_bus_arbiter;
    localparam int STARVE = 64;
    localparam int TMO    = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cgia_bus_arbiter_if bus ();

    cgia_bus_arbiter #(.CPU_STARVE_MAX(STARVE), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i   (clk),
        .reset_ni(rst_n),
        .bus     (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.vid_cyc_i = 0; bus.vid_stb_i = 0; bus.vid_adr_i = '0;
        bus.cpu_cyc_i = 0; bus.cpu_stb_i = 0; bus.cpu_we_i = 0;
        bus.cpu_sel_i = '0; bus.cpu_adr_i = '0; bus.cpu_dat_i = '0;
        bus.ack_i = 0; bus.dat_i = '0;
    endtask

    task automatic go_idle();
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({bus.gnt_o, bus.cyc_o, bus.stb_o, bus.vid_ack_o, bus.cpu_ack_o, bus.vid_err_o, bus.cpu_err_o} !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: got gnt=%b cyc=%b stb=%b acks=%b%b errs=%b%b want all 0",
                     bus.gnt_o, bus.cyc_o, bus.stb_o, bus.vid_ack_o, bus.cpu_ack_o, bus.vid_err_o, bus.cpu_err_o);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_transfer();
        bus.vid_cyc_i = 1; bus.vid_stb_i = 1; bus.ack_i = 1;
        tick();
        checks++;
        if (bus.vid_ack_o !== 1'b1 || bus.gnt_o !== 2'b01) begin
            errors++;
            $display("FAIL rst_mid_pre: got gnt=%b vid_ack=%b want 01/1", bus.gnt_o, bus.vid_ack_o);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.gnt_o, bus.cyc_o, bus.stb_o, bus.vid_ack_o} !== 5'b0) begin
            errors++;
            $display("FAIL rst_mid_async: got gnt=%b cyc=%b stb=%b vid_ack=%b want 0", bus.gnt_o, bus.cyc_o, bus.stb_o, bus.vid_ack_o);
        end
        #1 rst_n = 1'b1;
        go_idle();
    endtask

    task automatic test_priority_handover();
        bus.vid_cyc_i = 1; bus.vid_stb_i = 1; bus.cpu_cyc_i = 1; bus.cpu_stb_i = 1; bus.ack_i = 1;
        tick();
        checks++;
        if (bus.gnt_o !== 2'b01 || bus.cyc_o !== 1'b1) begin
            errors++;
            $display("FAIL prio_vid_first: got gnt=%b cyc=%b want 01/1", bus.gnt_o, bus.cyc_o);
        end
        repeat (4) tick();
        bus.vid_cyc_i = 0; bus.vid_stb_i = 0;
        #1;
        checks++;
        if (bus.cyc_o !== 1'b0 || bus.cpu_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL prio_vid_drop: got cyc=%b cpu_ack=%b want 0/0", bus.cyc_o, bus.cpu_ack_o);
        end
        tick();
        checks++;
        if (bus.gnt_o !== 2'b00 || bus.cyc_o !== 1'b0) begin
            errors++;
            $display("FAIL prio_idle_gap: got gnt=%b cyc=%b want 00/0", bus.gnt_o, bus.cyc_o);
        end
        tick();
        checks++;
        if (bus.gnt_o !== 2'b10 || bus.cyc_o !== 1'b1 || bus.cpu_ack_o !== 1'b1) begin
            errors++;
            $display("FAIL prio_cpu_next: got gnt=%b cyc=%b cpu_ack=%b want 10/1/1", bus.gnt_o, bus.cyc_o, bus.cpu_ack_o);
        end
        go_idle();
    endtask

    task automatic test_starvation();
        bus.vid_cyc_i = 1; bus.vid_stb_i = 1; bus.ack_i = 1;
        tick();
        repeat (9) tick();
        bus.cpu_cyc_i = 1; bus.cpu_stb_i = 1;
        repeat (STARVE) tick();
        checks++;
        if (bus.gnt_o !== 2'b01 || bus.vid_ack_o !== 1'b1 || bus.cpu_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL starve_last_vid: got gnt=%b vid_ack=%b cpu_ack=%b want 01/1/0", bus.gnt_o, bus.vid_ack_o, bus.cpu_ack_o);
        end
        tick();
        checks++;
        if (bus.gnt_o !== 2'b00 || bus.cyc_o !== 1'b0 || bus.vid_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL starve_release: got gnt=%b cyc=%b vid_ack=%b want 00/0/0", bus.gnt_o, bus.cyc_o, bus.vid_ack_o);
        end
        tick();
        checks++;
        if (bus.gnt_o !== 2'b10 || bus.cpu_ack_o !== 1'b1 || bus.vid_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL starve_cpu_grant: got gnt=%b cpu_ack=%b vid_ack=%b want 10/1/0", bus.gnt_o, bus.cpu_ack_o, bus.vid_ack_o);
        end
        bus.cpu_cyc_i = 0; bus.cpu_stb_i = 0;
        tick();
        tick();
        checks++;
        if (bus.gnt_o !== 2'b01) begin
            errors++;
            $display("FAIL starve_vid_regain: got gnt=%b want 01", bus.gnt_o);
        end
        go_idle();
    endtask

    task automatic test_cpu_write();
        bus.cpu_cyc_i = 1; bus.cpu_stb_i = 1; bus.cpu_we_i = 1; bus.cpu_sel_i = 2'b01;
        bus.cpu_adr_i = 23'h012345; bus.cpu_dat_i = 16'hBEEF;
        tick();
        bus.vid_cyc_i = 1; bus.vid_stb_i = 1; bus.vid_adr_i = 23'h7ABCDE;
        #1;
        checks++;
        if (bus.gnt_o !== 2'b10 || bus.adr_o !== 23'h012345 || bus.mdat_o !== 16'hBEEF ||
            bus.we_o !== 1'b1 || bus.sel_o !== 2'b01 || bus.cyc_o !== 1'b1 || bus.stb_o !== 1'b1) begin
            errors++;
            $display("FAIL cpu_write_bus: got gnt=%b adr=%h dat=%h we=%b sel=%b cyc=%b stb=%b want 10/012345/beef/1/01/1/1",
                     bus.gnt_o, bus.adr_o, bus.mdat_o, bus.we_o, bus.sel_o, bus.cyc_o, bus.stb_o);
        end
        bus.ack_i = 1; bus.dat_i = 16'h5A5A;
        #1;
        checks++;
        if (bus.cpu_ack_o !== 1'b1 || bus.vid_ack_o !== 1'b0 || bus.dat_o !== 16'h5A5A) begin
            errors++;
            $display("FAIL cpu_write_ack: got cpu_ack=%b vid_ack=%b dat_o=%h want 1/0/5a5a", bus.cpu_ack_o, bus.vid_ack_o, bus.dat_o);
        end
        go_idle();
    endtask

    task automatic test_late_ack();
        bus.cpu_cyc_i = 1; bus.cpu_stb_i = 1;
        tick();
        bus.vid_cyc_i = 1; bus.vid_stb_i = 1;
        bus.cpu_cyc_i = 0; bus.ack_i = 1;
        #1;
        checks++;
        if (bus.cpu_ack_o !== 1'b0 || bus.vid_ack_o !== 1'b0 || bus.cyc_o !== 1'b0 || bus.stb_o !== 1'b0) begin
            errors++;
            $display("FAIL late_ack: got cpu_ack=%b vid_ack=%b cyc=%b stb=%b want 0", bus.cpu_ack_o, bus.vid_ack_o, bus.cyc_o, bus.stb_o);
        end
        go_idle();
    endtask

    task automatic test_hung_slave();
        bus.cpu_cyc_i = 1; bus.cpu_stb_i = 1; bus.ack_i = 0;
        tick();
`ifdef ARB_TIMEOUT_EN
        for (int k = 1; k <= TMO; k++) begin
            checks++;
            if (bus.cpu_err_o !== (k == TMO) || bus.vid_err_o !== 1'b0 || bus.cyc_o !== 1'b1) begin
                errors++;
                $display("FAIL tmo_err_cycle%0d: got cpu_err=%b vid_err=%b cyc=%b want %b/0/1", k, bus.cpu_err_o, bus.vid_err_o, bus.cyc_o, k == TMO);
            end
            if (k < TMO) tick();
        end
        tick();
        checks++;
        if (bus.gnt_o !== 2'b00 || bus.cyc_o !== 1'b0 || bus.cpu_err_o !== 1'b0) begin
            errors++;
            $display("FAIL tmo_abort: got gnt=%b cyc=%b cpu_err=%b want 00/0/0", bus.gnt_o, bus.cyc_o, bus.cpu_err_o);
        end
        tick();
        checks++;
        if (bus.gnt_o !== 2'b00) begin
            errors++;
            $display("FAIL tmo_lockout: got gnt=%b want 00", bus.gnt_o);
        end
        bus.cpu_cyc_i = 0;
        tick();
        bus.cpu_cyc_i = 1;
        tick();
        checks++;
        if (bus.gnt_o !== 2'b10) begin
            errors++;
            $display("FAIL tmo_regrant: got gnt=%b want 10", bus.gnt_o);
        end
`else
        for (int k = 0; k < 1000; k++) begin
            checks++;
            if (bus.gnt_o !== 2'b10 || bus.cyc_o !== 1'b1 || bus.cpu_err_o !== 1'b0 || bus.vid_err_o !== 1'b0) begin
                errors++;
                $display("FAIL hung_hold cycle %0d: got gnt=%b cyc=%b errs=%b%b want 10/1/00", k, bus.gnt_o, bus.cyc_o, bus.vid_err_o, bus.cpu_err_o);
            end
            tick();
        end
`endif
        go_idle();
    endtask

    // Reference: owner 0/1/2 (none/VID/CPU), CPU wait age in cycles, slave stall age.
    task automatic test_random(input int n);
        int own = 0, wt = 0, stall = 0, n_own;
        bit bv = 0, bc = 0, hit, starved;
        logic [7:0]  got, exp;
        logic        e_cyc, e_stb;
        logic [23:1] e_adr;
        logic [1:0]  e_sel;
        for (int i = 0; i < n; i++) begin
            bus.vid_cyc_i = bus.vid_cyc_i ^ ($urandom_range(0, bus.vid_cyc_i ? 59 : 3) == 0);
            bus.cpu_cyc_i = bus.cpu_cyc_i ^ ($urandom_range(0, bus.cpu_cyc_i ? 11 : 9) == 0);
            bus.vid_stb_i = ($urandom_range(0, 3) != 0);
            bus.cpu_stb_i = ($urandom_range(0, 3) != 0);
            bus.ack_i     = ($urandom_range(0, 7) < 5);
            bus.vid_adr_i = 23'($urandom);
            bus.cpu_adr_i = 23'($urandom);
            bus.cpu_dat_i = 16'($urandom);
            bus.cpu_we_i  = 1'($urandom);
            bus.cpu_sel_i = 2'($urandom);
            bus.dat_i     = 16'($urandom);
            #1;
            e_cyc = (own == 1) ? bus.vid_cyc_i : (own == 2) ? bus.cpu_cyc_i : 1'b0;
            e_stb = e_cyc && ((own == 1) ? bus.vid_stb_i : bus.cpu_stb_i);
            hit = 0;
`ifdef ARB_TIMEOUT_EN
            hit = e_stb && !bus.ack_i && (stall == TMO - 1);
`endif
            exp = {2'(own), e_cyc, e_stb, own == 1 && e_stb && bus.ack_i, own == 2 && e_stb && bus.ack_i,
                   own == 1 && hit, own == 2 && hit};
            got = {bus.gnt_o, bus.cyc_o, bus.stb_o, bus.vid_ack_o, bus.cpu_ack_o, bus.vid_err_o, bus.cpu_err_o};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL rand_ctrl cycle %0d: got gnt/cyc/stb/acks/errs=%b want %b", i, got, exp);
            end
            if (own != 0) begin
                e_adr = (own == 1) ? bus.vid_adr_i : bus.cpu_adr_i;
                e_sel = (own == 1) ? 2'b11 : bus.cpu_sel_i;
                checks++;
                if (bus.adr_o !== e_adr || bus.sel_o !== e_sel || bus.we_o !== (own == 2 && bus.cpu_we_i) ||
                    (own == 2 && bus.mdat_o !== bus.cpu_dat_i) || bus.dat_o !== bus.dat_i) begin
                    errors++;
                    $display("FAIL rand_mux cycle %0d: got adr=%h sel=%b we=%b mdat=%h want adr=%h sel=%b", i,
                             bus.adr_o, bus.sel_o, bus.we_o, bus.mdat_o, e_adr, e_sel);
                end
            end
            starved = (wt >= STARVE);
            n_own = own;
            if (hit) n_own = 0;
            else if (own == 0) begin
                if ((bus.vid_cyc_i && !bv) && (bus.cpu_cyc_i && !bc)) n_own = starved ? 2 : 1;
                else if (bus.vid_cyc_i && !bv) n_own = 1;
                else if (bus.cpu_cyc_i && !bc) n_own = 2;
            end else if (own == 1) begin
                if (!bus.vid_cyc_i || (starved && bus.ack_i)) n_own = 0;
            end else if (!bus.cpu_cyc_i) n_own = 0;
            wt = (bus.cpu_cyc_i && own != 2) ? ((wt < STARVE) ? wt + 1 : STARVE) : 0;
            stall = (e_stb && !bus.ack_i && !hit) ? stall + 1 : 0;
            bv = (hit && own == 1) || (bv && bus.vid_cyc_i);
            bc = (hit && own == 2) || (bc && bus.cpu_cyc_i);
            own = n_own;
            tick();
        end
        go_idle();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_reset_mid_transfer();
        test_priority_handover();
        test_starvation();
        test_cpu_write();
        test_late_ack();
        test_hung_slave();
        test_random(4000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
